// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PULSE,
        GAP
    } arb_state_t;

    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_TIMEOUT = 255;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester streams, UART TX port and status flags of the arbiter in one bundle.
interface uart_tx_arbiter_if import uart_arb_pkg::*; #(
    parameter int N_REQ = DEFAULT_N_REQ
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               abort;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_send;
    logic               uart_tx_full;

    modport master (
        input  req_valid, req_data, req_last, uart_tx_full,
        output req_ready, grant_id, busy, abort, uart_tx_data, uart_tx_send
    );

    modport slave (
        output req_valid, req_data, req_last, uart_tx_full,
        input  req_ready, grant_id, busy, abort, uart_tx_data, uart_tx_send
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_picker import uart_arb_pkg::*; #(
    parameter int N_REQ = DEFAULT_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);
    localparam int ID_W = $clog2(N_REQ);

    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!found && req[ID_W'(cand)]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one edge-triggered UART TX port among N_REQ packet streams, holding
// the grant for a whole packet and releasing it on last byte or idle timeout.
module uart_tx_arbiter import uart_arb_pkg::*; #(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] timeout_cnt;
    logic             last_q;
    logic             found;
    logic [ID_W-1:0]  pick_idx;
    logic             take;
    logic [7:0]       grant_data;
    logic [ID_W-1:0]  next_ptr;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    // A byte moves only in LOAD, and only when the UART can take it.
    always_comb begin
        take          = (state == LOAD) && bus.req_valid[bus.grant_id] && !bus.uart_tx_full;
        grant_data    = bus.req_data[{bus.grant_id, 3'b000} +: 8];
        next_ptr      = ID_W'(wrap_inc(int'(bus.grant_id), N_REQ));
        bus.req_ready = '0;
        if (take) begin
            bus.req_ready[bus.grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            ptr              <= '0;
            timeout_cnt      <= '0;
            last_q           <= 1'b0;
            bus.grant_id     <= '0;
            bus.busy         <= 1'b0;
            bus.abort        <= 1'b0;
            bus.uart_tx_data <= 8'h00;
            bus.uart_tx_send <= 1'b0;
        end else begin
            bus.abort        <= 1'b0;
            bus.uart_tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.grant_id <= pick_idx;
                        timeout_cnt  <= '0;
                        bus.busy     <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    // A full UART freezes the timeout; only true requester silence counts.
                    if (take) begin
                        bus.uart_tx_data <= grant_data;
                        last_q           <= bus.req_last[bus.grant_id];
                        bus.uart_tx_send <= 1'b1;
                        state            <= PULSE;
                    end else if (!bus.uart_tx_full) begin
                        if (timeout_cnt >= CNT_W'(TIMEOUT - 1)) begin
                            timeout_cnt <= CNT_W'(TIMEOUT);
                            bus.abort   <= 1'b1;
                            ptr         <= next_ptr;
                            bus.busy    <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                        end
                    end
                end
                PULSE: begin
                    state <= GAP;
                end
                GAP: begin
                    if (last_q) begin
                        ptr      <= next_ptr;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timeout_cnt <= '0;
                        state       <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random packet traffic
// checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    typedef struct { logic [7:0] data; int gid; int cyc; } strobe_t;
    typedef struct { int idx; int cyc; } ready_t;
    typedef struct { int gid; logic [7:0] data; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus();
    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [8:0] txq [N][$];
    logic [8:0] mq [N][$];
    bit         mid [N];
    int         gap [N];
    strobe_t    strb_log[$];
    ready_t     rdy_log[$];
    int         abort_log[$];
    exp_t       exp_q[$];
    int         busy_fall;
    int         cyc = 0;
    int         check_cnt = 0;
    int         pass_cnt = 0;
    int         ready_err = 0;
    int         width_err = 0;
    bit         rnd_mode = 1'b0;
    logic       prev_send = 1'b0;
    logic       prev_busy = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_cnt++;
        if (got === want) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic int now();
        return cyc + 1;
    endfunction

    function automatic bit allEmpty();
        for (int i = 0; i < N; i++) if (txq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic driveInputs();
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [8*N-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            d[8*i +: 8] = 8'($urandom);
            if (txq[i].size() > 0) begin
                if (gap[i] > 0) gap[i]--;
                else begin
                    v[i]        = 1'b1;
                    d[8*i +: 8] = txq[i][0][7:0];
                    l[i]        = txq[i][0][8];
                end
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        if (rnd_mode) bus.uart_tx_full = ($urandom_range(0, 3) == 0);
    endtask

    // One clock: observe at the falling edge, retire accepted bytes just after the rising edge.
    task automatic applyStimulus();
        logic [N-1:0] hs;
        strobe_t      s;
        ready_t       r;
        @(negedge clk);
        cyc++;
        hs = bus.req_valid & bus.req_ready;
        if (((bus.req_ready & ~bus.req_valid) != '0) || !$onehot0(bus.req_ready)) ready_err++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                r.idx = i;
                r.cyc = cyc;
                rdy_log.push_back(r);
            end
        end
        if (bus.uart_tx_send && !prev_send) begin
            s.data = bus.uart_tx_data;
            s.gid  = int'(bus.grant_id);
            s.cyc  = cyc;
            strb_log.push_back(s);
        end
        if (bus.uart_tx_send && prev_send) width_err++;
        if (bus.abort) abort_log.push_back(cyc);
        if (prev_busy && !bus.busy) busy_fall = cyc;
        prev_send = bus.uart_tx_send;
        prev_busy = bus.busy;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && txq[i].size() > 0) begin
                mid[i] = !txq[i][0][8];
                if (rnd_mode && mid[i] && $urandom_range(0, 3) == 0) gap[i] = $urandom_range(1, 3);
                void'(txq[i].pop_front());
            end
        end
        driveInputs();
    endtask

    task automatic runUntilIdle(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !(allEmpty() && !bus.busy)) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
        applyStimulus();
        applyStimulus();
    endtask

    task automatic clearLogs();
        strb_log.delete();
        rdy_log.delete();
        abort_log.delete();
        exp_q.delete();
        busy_fall = -1;
    endtask

    task automatic expPush(input int gid, input logic [7:0] data);
        exp_t e;
        e.gid  = gid;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic checkSeq(input string tag);
        checkOutput({tag, "_count"}, 32'(strb_log.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < strb_log.size(); k++) begin
            checkOutput($sformatf("%s_data%0d", tag, k), 32'(strb_log[k].data), 32'(exp_q[k].data));
            checkOutput($sformatf("%s_gid%0d", tag, k), 32'(strb_log[k].gid), 32'(exp_q[k].gid));
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            txq[i].delete();
            mid[i] = 1'b0;
            gap[i] = 0;
        end
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.req_last     = '0;
        bus.uart_tx_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        prev_send = 1'b0;
        prev_busy = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int f;
        int s;
        int n;
        int r0cyc;
        int mptr;
        bit got;
        logic [8:0] b;

        resetDut();
        checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_grant", 32'(bus.grant_id), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_abort", 32'(bus.abort), 32'd0);
        checkOutput("rst_data", 32'(bus.uart_tx_data), 32'd0);
        checkOutput("rst_send", 32'(bus.uart_tx_send), 32'd0);

        // Single requester, two-byte packet: latency and strobe spacing.
        clearLogs();
        t0 = now();
        txq[1].push_back(9'h041);
        txq[1].push_back(9'h142);
        driveInputs();
        runUntilIdle("t1_done", 100);
        checkOutput("t1_count", 32'(strb_log.size()), 32'd2);
        if (rdy_log.size() > 0) checkOutput("t1_ready_cyc", 32'(rdy_log[0].cyc), 32'(t0 + 1));
        if (strb_log.size() >= 2) begin
            checkOutput("t1_gid", 32'(strb_log[0].gid), 32'd1);
            checkOutput("t1_data0", 32'(strb_log[0].data), 32'h41);
            checkOutput("t1_cyc0", 32'(strb_log[0].cyc), 32'(t0 + 2));
            checkOutput("t1_data1", 32'(strb_log[1].data), 32'h42);
            checkOutput("t1_cyc1", 32'(strb_log[1].cyc), 32'(t0 + 5));
        end
        checkOutput("t1_busy_fall", 32'(busy_fall), 32'(t0 + 7));

        // Round robin from a fresh reset; requester 0 re-requests behind 3.
        resetDut();
        clearLogs();
        txq[0].push_back(9'h110);
        txq[0].push_back(9'h150);
        txq[1].push_back(9'h120);
        txq[2].push_back(9'h130);
        txq[3].push_back(9'h140);
        driveInputs();
        runUntilIdle("t2_done", 200);
        expPush(0, 8'h10); expPush(1, 8'h20); expPush(2, 8'h30); expPush(3, 8'h40); expPush(0, 8'h50);
        checkSeq("t2");

        // Packet lock: requester 2 holds the port while 0 waits.
        clearLogs();
        txq[2].push_back(9'h0A1);
        txq[2].push_back(9'h0A2);
        txq[2].push_back(9'h1A3);
        txq[0].push_back(9'h10F);
        driveInputs();
        runUntilIdle("t3_done", 200);
        expPush(2, 8'hA1); expPush(2, 8'hA2); expPush(2, 8'hA3); expPush(0, 8'h0F);
        checkSeq("t3");
        r0cyc = -1;
        foreach (rdy_log[k]) if (r0cyc < 0 && rdy_log[k].idx == 0) r0cyc = rdy_log[k].cyc;
        if (strb_log.size() >= 3)
            checkOutput("t3_lock", (r0cyc > strb_log[2].cyc) ? 32'd1 : 32'd0, 32'd1);

        // Backpressure: 20 cycles of full in LOAD.
        clearLogs();
        bus.uart_tx_full = 1'b1;
        txq[1].push_back(9'h177);
        driveInputs();
        repeat (22) applyStimulus();
        checkOutput("t4_no_strobe", 32'(strb_log.size()), 32'd0);
        checkOutput("t4_no_ready", 32'(rdy_log.size()), 32'd0);
        checkOutput("t4_no_abort", 32'(abort_log.size()), 32'd0);
        checkOutput("t4_busy", 32'(bus.busy), 32'd1);
        checkOutput("t4_grant", 32'(bus.grant_id), 32'd1);
        bus.uart_tx_full = 1'b0;
        f = now();
        runUntilIdle("t4_done", 100);
        if (rdy_log.size() > 0) checkOutput("t4_ready_cyc", 32'(rdy_log[0].cyc), 32'(f));
        checkOutput("t4_count", 32'(strb_log.size()), 32'd1);
        if (strb_log.size() > 0) begin
            checkOutput("t4_cyc", 32'(strb_log[0].cyc), 32'(f + 1));
            checkOutput("t4_data", 32'(strb_log[0].data), 32'h77);
        end
        checkOutput("t4_abort", 32'(abort_log.size()), 32'd0);

        // Timeout: requester 3 goes silent mid-packet.
        clearLogs();
        txq[3].push_back(9'h033);
        driveInputs();
        runUntilIdle("t5_done", 100);
        checkOutput("t5_count", 32'(strb_log.size()), 32'd1);
        s = (strb_log.size() > 0) ? strb_log[0].cyc : 0;
        checkOutput("t5_abort_n", 32'(abort_log.size()), 32'd1);
        if (abort_log.size() > 0) checkOutput("t5_abort_cyc", 32'(abort_log[0]), 32'(s + 10));
        checkOutput("t5_busy_fall", 32'(busy_fall), 32'(s + 10));
        clearLogs();
        txq[1].push_back(9'h10B);
        txq[0].push_back(9'h10A);
        driveInputs();
        runUntilIdle("t5_next_done", 100);
        expPush(0, 8'h0A); expPush(1, 8'h0B);
        checkSeq("t5_next");

        // Byte returning in the very cycle the timeout would expire.
        clearLogs();
        txq[2].push_back(9'h021);
        driveInputs();
        n = 0;
        while (strb_log.size() == 0 && n < 50) begin
            applyStimulus();
            n++;
        end
        s = (strb_log.size() > 0) ? strb_log[0].cyc : 0;
        while (now() < s + 9 && n < 100) begin
            applyStimulus();
            n++;
        end
        txq[2].push_back(9'h122);
        driveInputs();
        runUntilIdle("t5b_done", 100);
        checkOutput("t5b_abort", 32'(abort_log.size()), 32'd0);
        checkOutput("t5b_count", 32'(strb_log.size()), 32'd2);
        if (strb_log.size() >= 2) begin
            checkOutput("t5b_data", 32'(strb_log[1].data), 32'h22);
            checkOutput("t5b_cyc", 32'(strb_log[1].cyc), 32'(s + 10));
        end

        // Asynchronous reset while the strobe is high.
        clearLogs();
        txq[1].push_back(9'h061);
        txq[1].push_back(9'h162);
        driveInputs();
        n = 0;
        while (rdy_log.size() == 0 && n < 50) begin
            applyStimulus();
            n++;
        end
        checkOutput("t6_in_pulse", 32'(bus.uart_tx_send), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_send", 32'(bus.uart_tx_send), 32'd0);
        checkOutput("t6_busy", 32'(bus.busy), 32'd0);
        checkOutput("t6_grant", 32'(bus.grant_id), 32'd0);
        resetDut();
        clearLogs();
        txq[2].push_back(9'h1C2);
        txq[0].push_back(9'h1C0);
        driveInputs();
        runUntilIdle("t6_done", 100);
        expPush(0, 8'hC0); expPush(2, 8'hC2);
        checkSeq("t6");

        // Random packets with short gaps and random full, against a packet-level model.
        resetDut();
        mptr = 0;
        rnd_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            clearLogs();
            for (int i = 0; i < N; i++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) begin
                        b = {(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)};
                        txq[i].push_back(b);
                        mq[i].push_back(b);
                    end
                end
            end
            forever begin
                got = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (mptr + k) % N;
                    if (!got && mq[i].size() > 0) begin
                        got = 1'b1;
                        do begin
                            b = mq[i].pop_front();
                            expPush(i, b[7:0]);
                        end while (!b[8]);
                        mptr = (i + 1) % N;
                    end
                end
                if (!got) break;
            end
            driveInputs();
            runUntilIdle($sformatf("rnd%0d_done", r), 3000);
            checkSeq($sformatf("rnd%0d", r));
            checkOutput($sformatf("rnd%0d_abort", r), 32'(abort_log.size()), 32'd0);
        end
        rnd_mode = 1'b0;
        bus.uart_tx_full = 1'b0;

        checkOutput("ready_onehot", 32'(ready_err), 32'd0);
        checkOutput("send_width", 32'(width_err), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
